// File: rtl/sine_phase_sequencer_pkg.sv
// Shared sizing defaults, phase offsets and FSM state encoding for the
// three-phase sine sequencer.
package sine_seq_pkg;

  localparam int DEF_ACC_W  = 24;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

  // 120 and 240 degrees expressed as fractions of a 16-bit phase circle.
  localparam logic [15:0] PHASE_120 = 16'h5555;
  localparam logic [15:0] PHASE_240 = 16'hAAAB;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_U = 3'd1,
    FETCH_V = 3'd2,
    FETCH_W = 3'd3,
    DONE    = 3'd4
  } seq_state_e;

endpackage

// File: rtl/sine_phase_sequencer_if.sv
// Control, table and duty signals of the sequencer, bundled as one bus.
// The master side is the parent (tick source and sine table owner).
interface sine_phase_sequencer_if
  import sine_seq_pkg::*;
#(
  parameter int ACC_W  = DEF_ACC_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              enable;
  logic              sample_tick;
  logic [ACC_W-1:0]  freq_word;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] duty_u;
  logic [DATA_W-1:0] duty_v;
  logic [DATA_W-1:0] duty_w;
  logic              samples_valid;
  logic              busy;
  logic              overrun;

  modport master (
    output enable, sample_tick, freq_word, rom_data,
    input  rom_addr, duty_u, duty_v, duty_w, samples_valid, busy, overrun
  );

  modport slave (
    input  enable, sample_tick, freq_word, rom_data,
    output rom_addr, duty_u, duty_v, duty_w, samples_valid, busy, overrun
  );

endinterface

// File: rtl/sine_phase_sequencer_acc.sv
// Phase accumulator: adds the increment on load and exposes both the
// current phase and the phase the next load would produce.
module sine_phase_acc
  import sine_seq_pkg::*;
#(
  parameter int ACC_W  = DEF_ACC_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [ACC_W-1:0]  i_incr,
  output logic [ADDR_W-1:0] o_phase,
  output logic [ADDR_W-1:0] o_phase_next
);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_sum;

  // Wraps silently modulo 2^ACC_W.
  assign w_acc_sum = r_acc + i_incr;

  // Accumulator register, advanced only when a sequence is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= w_acc_sum;
    end else begin
      r_acc <= r_acc;
    end
  end

  assign o_phase      = r_acc[ACC_W-1 -: ADDR_W];
  assign o_phase_next = w_acc_sum[ACC_W-1 -: ADDR_W];

endmodule

// File: rtl/sine_phase_sequencer.sv
// Three-phase sine sequencer: on each accepted tick it advances the phase
// accumulator and reads the shared sine table at 0, 120 and 240 degrees,
// then presents all three samples together for one valid cycle.
module sine_phase_sequencer
  import sine_seq_pkg::*;
#(
  parameter int ACC_W  = DEF_ACC_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  sine_phase_sequencer_if.slave  sif
);

  seq_state_e        r_state;
  seq_state_e        w_state_next;
  logic              w_acc_load;
  logic [ADDR_W-1:0] w_addr_next;
  logic              w_cap_u;
  logic              w_cap_v;
  logic              w_commit;
  logic              w_valid_next;
  logic              w_overrun_set;
  logic [ADDR_W-1:0] w_phase;
  logic [ADDR_W-1:0] w_phase_next;

  logic [ADDR_W-1:0] r_rom_addr;
  logic [DATA_W-1:0] r_shadow_u;
  logic [DATA_W-1:0] r_shadow_v;
  logic [DATA_W-1:0] r_duty_u;
  logic [DATA_W-1:0] r_duty_v;
  logic [DATA_W-1:0] r_duty_w;
  logic              r_samples_valid;
  logic              r_busy;
  logic              r_overrun;

  sine_phase_acc #(
    .ACC_W  (ACC_W),
    .ADDR_W (ADDR_W)
  ) u_acc (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_acc_load),
    .i_incr       (sif.freq_word),
    .o_phase      (w_phase),
    .o_phase_next (w_phase_next)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    w_state_next = r_state;
    w_acc_load   = 1'b0;
    w_addr_next  = r_rom_addr;
    w_cap_u      = 1'b0;
    w_cap_v      = 1'b0;
    w_commit     = 1'b0;
    w_valid_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (sif.enable && sif.sample_tick) begin
          w_acc_load   = 1'b1;
          w_addr_next  = w_phase_next;
          w_state_next = FETCH_U;
        end else begin
          w_state_next = IDLE;
        end
      end
      FETCH_U: begin
        w_cap_u      = 1'b1;
        w_addr_next  = w_phase + ADDR_W'(PHASE_120);
        w_state_next = FETCH_V;
      end
      FETCH_V: begin
        w_cap_v      = 1'b1;
        w_addr_next  = w_phase + ADDR_W'(PHASE_240);
        w_state_next = FETCH_W;
      end
      FETCH_W: begin
        w_commit     = 1'b1;
        w_valid_next = 1'b1;
        w_state_next = DONE;
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Any tick outside IDLE is dropped and flagged, whatever enable says.
  assign w_overrun_set = sif.sample_tick && (r_state != IDLE);

  // Table address, shadow captures and simultaneous duty update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rom_addr <= '0;
      r_shadow_u <= '0;
      r_shadow_v <= '0;
      r_duty_u   <= '0;
      r_duty_v   <= '0;
      r_duty_w   <= '0;
    end else begin
      r_rom_addr <= w_addr_next;
      if (w_cap_u) begin
        r_shadow_u <= sif.rom_data;
      end
      if (w_cap_v) begin
        r_shadow_v <= sif.rom_data;
      end
      if (w_commit) begin
        r_duty_u <= r_shadow_u;
        r_duty_v <= r_shadow_v;
        r_duty_w <= sif.rom_data;
      end
    end
  end

  // Registered status: valid pulse in DONE, busy outside IDLE, sticky overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_samples_valid <= 1'b0;
      r_busy          <= 1'b0;
      r_overrun       <= 1'b0;
    end else begin
      r_samples_valid <= w_valid_next;
      r_busy          <= (w_state_next != IDLE);
      r_overrun       <= r_overrun | w_overrun_set;
    end
  end

  assign sif.rom_addr      = r_rom_addr;
  assign sif.duty_u        = r_duty_u;
  assign sif.duty_v        = r_duty_v;
  assign sif.duty_w        = r_duty_w;
  assign sif.samples_valid = r_samples_valid;
  assign sif.busy          = r_busy;
  assign sif.overrun       = r_overrun;

endmodule

// File: tb/tb_sine_phase_sequencer.sv
// Directed bench for sine_phase_sequencer with a sample-set scoreboard.
// The sine table is modelled as rom_data = rom_addr[15:8].
module tb_sine_phase_sequencer;

  typedef struct packed {
    logic [7:0] u;
    logic [7:0] v;
    logic [7:0] w;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  int checks = 0;
  int errors = 0;

  exp_t        q[$];
  logic [23:0] m_acc = 24'h0;
  logic        m_ovr = 1'b0;
  logic [23:0] last_duty = 24'h0;

  sine_phase_sequencer_if bus_if ();

  assign bus_if.rom_data = bus_if.rom_addr[15:8];

  sine_phase_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .sif   (bus_if)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [15:0] a);
    return a[15:8];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: pops on every valid pulse, otherwise duties must hold.
  always @(negedge clk) begin
    if (reset) begin
      last_duty = 24'h0;
    end else if (bus_if.samples_valid) begin
      check("valid_expected", {31'h0, (q.size() > 0)}, 32'h1);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check("duty_u", {24'h0, bus_if.duty_u}, {24'h0, e.u});
        check("duty_v", {24'h0, bus_if.duty_v}, {24'h0, e.v});
        check("duty_w", {24'h0, bus_if.duty_w}, {24'h0, e.w});
      end
      last_duty = {bus_if.duty_u, bus_if.duty_v, bus_if.duty_w};
    end else begin
      check("duty_hold", {8'h0, bus_if.duty_u, bus_if.duty_v, bus_if.duty_w},
            {8'h0, last_duty});
    end
  end

  task automatic do_reset();
    #1 reset = 1'b1;
    #1;
    check("rst_rom_addr", {16'h0, bus_if.rom_addr}, 32'h0);
    check("rst_duties", {8'h0, bus_if.duty_u, bus_if.duty_v, bus_if.duty_w}, 32'h0);
    check("rst_valid", {31'h0, bus_if.samples_valid}, 32'h0);
    check("rst_busy", {31'h0, bus_if.busy}, 32'h0);
    check("rst_overrun", {31'h0, bus_if.overrun}, 32'h0);
    m_acc = 24'h0;
    m_ovr = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One full sequence; optionally a second tick during FETCH_V (T2).
  task automatic run_seq(input logic [23:0] fw, input bit extra_tick);
    logic [15:0] ph;
    logic [15:0] pv;
    logic [15:0] pw;
    @(posedge clk); #1;
    bus_if.freq_word   = fw;
    bus_if.sample_tick = 1'b1;
    m_acc = m_acc + fw;
    ph = m_acc[23:8];
    pv = ph + 16'h5555;
    pw = ph + 16'hAAAB;
    q.push_back('{u: rom(ph), v: rom(pv), w: rom(pw)});
    @(posedge clk); #1;                       // T1
    bus_if.sample_tick = 1'b0;
    check("addr_u", {16'h0, bus_if.rom_addr}, {16'h0, ph});
    check("busy_t1", {31'h0, bus_if.busy}, 32'h1);
    @(posedge clk); #1;                       // T2
    check("addr_v", {16'h0, bus_if.rom_addr}, {16'h0, pv});
    if (extra_tick) begin
      bus_if.sample_tick = 1'b1;
      bus_if.freq_word   = 24'h123456;
      m_ovr = 1'b1;
    end
    @(posedge clk); #1;                       // T3
    bus_if.sample_tick = 1'b0;
    check("addr_w", {16'h0, bus_if.rom_addr}, {16'h0, pw});
    check("valid_t3", {31'h0, bus_if.samples_valid}, 32'h0);
    @(posedge clk); #1;                       // T4
    check("valid_t4", {31'h0, bus_if.samples_valid}, 32'h1);
    check("addr_hold_done", {16'h0, bus_if.rom_addr}, {16'h0, pw});
    @(posedge clk); #1;                       // T5
    check("busy_t5", {31'h0, bus_if.busy}, 32'h0);
    check("valid_t5", {31'h0, bus_if.samples_valid}, 32'h0);
    check("addr_hold_idle", {16'h0, bus_if.rom_addr}, {16'h0, pw});
    check("overrun", {31'h0, bus_if.overrun}, {31'h0, m_ovr});
  endtask

  initial begin
    int budget;
    bus_if.enable      = 1'b1;
    bus_if.sample_tick = 1'b0;
    bus_if.freq_word   = 24'h0;

    // Reset state, then basic sequence from acc=0.
    do_reset();
    run_seq(24'h001000, 1'b0);

    // Accumulator wrap across two ticks.
    do_reset();
    run_seq(24'hFFF000, 1'b0);
    run_seq(24'hFFF000, 1'b0);

    // Zero increment: both sets identical at 0x0000/0x5555/0xAAAB.
    do_reset();
    run_seq(24'h000000, 1'b0);
    run_seq(24'h000000, 1'b0);

    // Tick while busy: dropped, overrun sticks; next tick shows single advance.
    do_reset();
    run_seq(24'h002300, 1'b1);
    run_seq(24'h000100, 1'b0);

    // Ticks with enable low are ignored.
    do_reset();
    bus_if.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus_if.freq_word   = 24'h004000;
      bus_if.sample_tick = 1'b1;
      @(posedge clk); #1;
      bus_if.sample_tick = 1'b0;
      check("dis_busy", {31'h0, bus_if.busy}, 32'h0);
      check("dis_overrun", {31'h0, bus_if.overrun}, 32'h0);
    end
    repeat (5) @(posedge clk);
    #1;
    check("dis_busy_end", {31'h0, bus_if.busy}, 32'h0);
    bus_if.enable = 1'b1;

    // Reset asserted in FETCH_V, then the basic sequence again.
    @(posedge clk); #1;
    bus_if.freq_word   = 24'h001000;
    bus_if.sample_tick = 1'b1;
    @(posedge clk); #1;
    bus_if.sample_tick = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", {31'h0, bus_if.busy}, 32'h1);
    check("mid_addr_v", {16'h0, bus_if.rom_addr}, 32'h00005565);
    do_reset();
    run_seq(24'h001000, 1'b0);

    // Drain: every pushed expectation must have been consumed.
    budget = 0;
    while (q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    check("scoreboard_empty", q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
